// File: rtl/tl_user_arb.sv
// Round-robin arbiter multiplexing NUM_REQ user requesters onto one transaction-layer
// command channel and one write-data channel. Define TL_USER_ARB_WDOG_EN to add the DATA-phase watchdog.
module tl_user_arb #(
  parameter int NUM_REQ  = 2,
  parameter int CMD_W    = 128,
  parameter int DATA_W   = 146,
  parameter int WDOG_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_cmd_valid,
  input  logic [NUM_REQ*CMD_W-1:0]  req_cmd,
  input  logic [NUM_REQ-1:0]        req_cmd_wr,
  output logic [NUM_REQ-1:0]        req_cmd_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_wvalid,
  input  logic [NUM_REQ-1:0]        req_weop,
  output logic [NUM_REQ-1:0]        req_wready,
  output logic [CMD_W-1:0]          cmd,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [DATA_W-1:0]         wdata,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [2:0]                gnt_id,
  output logic                      busy,
  output logic                      wdog_err
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;

  logic              sel_cmd_valid;
  logic              sel_cmd_wr;
  logic              sel_wvalid;
  logic              sel_weop;
  logic [CMD_W-1:0]  sel_cmd;
  logic [DATA_W-1:0] sel_wdata;

  logic                 any_req;
  logic [2*NUM_REQ-1:0] vld_dbl;
  logic [NUM_REQ-1:0]   vld_rot;
  logic [2:0]           rr_win;
  logic                 wdog_hit;

  // Signals of the current owner
  always_comb begin
    sel_cmd_valid = 1'b0;
    sel_cmd_wr    = 1'b0;
    sel_wvalid    = 1'b0;
    sel_weop      = 1'b0;
    sel_cmd       = '0;
    sel_wdata     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id_q == 3'(i)) begin
        sel_cmd_valid = req_cmd_valid[i];
        sel_cmd_wr    = req_cmd_wr[i];
        sel_wvalid    = req_wvalid[i];
        sel_weop      = req_weop[i];
        sel_cmd       = req_cmd[i*CMD_W +: CMD_W];
        sel_wdata     = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Rotate the valid vector so bit 0 is rr_ptr; the first set bit is the winner.
  always_comb begin : rr_search
    int unsigned idx;
    logic        found;
    idx     = '0;
    found   = 1'b0;
    any_req = |req_cmd_valid;
    vld_dbl = {req_cmd_valid, req_cmd_valid} >> rr_ptr_q;
    vld_rot = vld_dbl[NUM_REQ-1:0];
    rr_win  = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && vld_rot[k]) begin
        found = 1'b1;
        idx   = 32'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        rr_win = 3'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_id_d      = gnt_id_q;
    rr_ptr_d      = rr_ptr_q;
    cmd_valid     = 1'b0;
    cmd           = '0;
    req_cmd_ready = '0;
    wvalid        = 1'b0;
    wdata         = '0;
    req_wready    = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_id_d = rr_win;
          state_d  = CMD;
        end
      end
      CMD: begin
        cmd_valid     = sel_cmd_valid;
        cmd           = sel_cmd_valid ? sel_cmd : '0;
        req_cmd_ready = NUM_REQ'(cmd_ready) << gnt_id_q;
        if (sel_cmd_valid && cmd_ready) begin
          rr_ptr_d = (gnt_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_id_q + 3'd1;
          state_d  = sel_cmd_wr ? DATA : IDLE;
        end
      end
      DATA: begin
        wvalid     = sel_wvalid;
        wdata      = sel_wvalid ? sel_wdata : '0;
        req_wready = NUM_REQ'(wready) << gnt_id_q;
        if (sel_wvalid && wready && sel_weop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wdog_hit) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef TL_USER_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

  // Counts consecutive DATA cycles without a beat; fires on the WDOG_CYC-th one.
  always_comb begin
    wdog_cnt_d = '0;
    wdog_hit   = 1'b0;
    if (state_q == DATA && !(sel_wvalid && wready)) begin
      if (wdog_cnt_q == WDOG_W'(WDOG_CYC - 1)) begin
        wdog_hit = 1'b1;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
    end
  end

  assign wdog_err = wdog_hit;
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  assign gnt_id = gnt_id_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_tl_user_arb.sv
// Directed bench for tl_user_arb: transaction-level reference model checked every cycle,
// plus hand-computed expectations for grant order, latency, write locking and reset.
module tb_tl_user_arb;
  localparam int NUM_REQ  = 2;
  localparam int CMD_W    = 128;
  localparam int DATA_W   = 146;
  localparam int WDOG_CYC = 1024;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_cmd_valid;
  logic [NUM_REQ*CMD_W-1:0]  req_cmd;
  logic [NUM_REQ-1:0]        req_cmd_wr;
  logic [NUM_REQ-1:0]        req_cmd_ready;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_wvalid;
  logic [NUM_REQ-1:0]        req_weop;
  logic [NUM_REQ-1:0]        req_wready;
  logic [CMD_W-1:0]          cmd;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [DATA_W-1:0]         wdata;
  logic                      wvalid;
  logic                      wready;
  logic [2:0]                gnt_id;
  logic                      busy;
  logic                      wdog_err;

  tl_user_arb #(
    .NUM_REQ (NUM_REQ),
    .CMD_W   (CMD_W),
    .DATA_W  (DATA_W),
    .WDOG_CYC(WDOG_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_cmd_valid(req_cmd_valid),
    .req_cmd      (req_cmd),
    .req_cmd_wr   (req_cmd_wr),
    .req_cmd_ready(req_cmd_ready),
    .req_wdata    (req_wdata),
    .req_wvalid   (req_wvalid),
    .req_weop     (req_weop),
    .req_wready   (req_wready),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .wdata        (wdata),
    .wvalid       (wvalid),
    .wready       (wready),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .wdog_err     (wdog_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: phase 0 = idle, 1 = command offered, 2 = write data locked.
  int m_phase = 0;
  int m_owner = 0;
  int m_rr    = 0;
  int m_stall = 0;
  bit m_live  = 1'b0;

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int rr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
    return 0;
  endfunction

  function automatic logic exp_wdog();
`ifdef TL_USER_ARB_WDOG_EN
    return (m_phase == 2) && !(req_wvalid[m_owner] && wready) && (m_stall == WDOG_CYC - 1);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_owner <= 0;
      m_rr    <= 0;
      m_stall <= 0;
      m_live  <= 1'b1;
    end else begin
      case (m_phase)
        0: if (req_cmd_valid != '0) begin
          m_owner <= rr_pick(req_cmd_valid, m_rr);
          m_phase <= 1;
        end
        1: begin
          m_stall <= 0;
          if (req_cmd_valid[m_owner] && cmd_ready) begin
            m_rr    <= (m_owner + 1) % NUM_REQ;
            m_phase <= req_cmd_wr[m_owner] ? 2 : 0;
          end
        end
        2: if (req_wvalid[m_owner] && wready) begin
          m_stall <= 0;
          if (req_weop[m_owner]) m_phase <= 0;
        end
`ifdef TL_USER_ARB_WDOG_EN
        else if (m_stall == WDOG_CYC - 1) begin
          m_phase <= 0;
          m_stall <= 0;
        end else begin
          m_stall <= m_stall + 1;
        end
`endif
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("busy", busy, m_phase != 0);
      if (m_phase != 0) chk("gnt_id", gnt_id, m_owner);
      chk("cmd_valid", cmd_valid, (m_phase == 1) && req_cmd_valid[m_owner]);
      chk("cmd", cmd, ((m_phase == 1) && req_cmd_valid[m_owner]) ? req_cmd[m_owner*CMD_W +: CMD_W] : '0);
      chk("req_cmd_ready", req_cmd_ready, ((m_phase == 1) && cmd_ready) ? (NUM_REQ'(1) << m_owner) : '0);
      chk("wvalid", wvalid, (m_phase == 2) && req_wvalid[m_owner]);
      chk("wdata", wdata, ((m_phase == 2) && req_wvalid[m_owner]) ? req_wdata[m_owner*DATA_W +: DATA_W] : '0);
      chk("req_wready", req_wready, ((m_phase == 2) && wready) ? (NUM_REQ'(1) << m_owner) : '0);
      chk("wdog_err", wdog_err, exp_wdog());
    end
  end

  logic             snap_cv, snap_busy, snap_wv, snap_wdog;
  logic [CMD_W-1:0] snap_cmd;
  logic [2:0]       snap_gnt;

  task automatic cycle(output logic [NUM_REQ-1:0] ch, output logic [NUM_REQ-1:0] wh);
    @(negedge clk);
    ch        = req_cmd_valid & req_cmd_ready;
    wh        = req_wvalid & req_wready;
    snap_cv   = cmd_valid;
    snap_cmd  = cmd;
    snap_busy = busy;
    snap_gnt  = gnt_id;
    snap_wv   = wvalid;
    snap_wdog = wdog_err;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [CMD_W-1:0] v);
    req_cmd[i*CMD_W +: CMD_W] = v;
  endtask

  task automatic set_beat(input int i, input int b, input bit last);
    req_wdata[i*DATA_W +: DATA_W] = {{4{32'hDA7A_0000 + 32'(i * 16 + b)}}, 16'hFFFF, b == 0, last};
    req_weop[i]   = last;
    req_wvalid[i] = 1'b1;
  endtask

  localparam logic [CMD_W-1:0] C0 = {4{32'hC0C0_0000}};
  localparam logic [CMD_W-1:0] C1 = {4{32'hC1C1_1111}};
  localparam logic [CMD_W-1:0] C2 = {4{32'hC2C2_2222}};
  localparam logic [CMD_W-1:0] C3 = {4{32'hC3C3_3333}};
  localparam logic [CMD_W-1:0] C4 = {4{32'hC4C4_4444}};
  localparam logic [CMD_W-1:0] C5 = {4{32'hC5C5_5555}};

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [NUM_REQ-1:0] h, w;
    int g_id[8];
    int g_it[8];
    int g_n, nb, c0_it, c1_it, hold_ok, pulses, pulse_n;
    int beat_it[4];

    rst_n = 1'b0; req_cmd = '0; req_wdata = '0; req_cmd_wr = '0; req_wvalid = '0;
    req_weop = '0; cmd_ready = 1'b0; wready = 1'b0;
    req_cmd_valid = '1;
    cycle(h, w);
    cycle(h, w);
    chk("rst_busy", snap_busy, 1'b0);
    chk("rst_cmd_valid", snap_cv, 1'b0);
    chk("rst_gnt", snap_gnt, 3'd0);
    req_cmd_valid = '0;
    wready = 1'b1;
    rst_n = 1'b1;
    cycle(h, w);

    // Simultaneous read commands: req0 first, req1 two cycles later
    set_cmd(0, C0); set_cmd(1, C1);
    cmd_ready = 1'b1; req_cmd_wr = '0; req_cmd_valid = 2'b11;
    g_n = 0;
    foreach (g_id[i]) begin g_id[i] = -1; g_it[i] = -1; end
    for (int it = 1; it <= 20; it++) begin
      cycle(h, w);
      for (int i = 0; i < NUM_REQ; i++) if (h[i]) begin
        g_id[g_n] = i; g_it[g_n] = it; g_n++; req_cmd_valid[i] = 1'b0;
      end
      if (g_n == 2) break;
    end
    chk("t036_first_gnt", g_id[0], 0);
    chk("t036_second_gnt", g_id[1], 1);
    chk("t036_first_hs_cycle", g_it[0], 2);
    chk("t036_second_hs_cycle", g_it[1], 4);
    cycle(h, w);

    // req1 4-beat write; req0 read posted while req1 owns the channels
    set_cmd(1, C2); set_cmd(0, C3);
    req_cmd_wr = 2'b10; req_cmd_valid = 2'b10;
    nb = 0; c0_it = -1; c1_it = -1;
    foreach (beat_it[i]) beat_it[i] = -1;
    set_beat(1, 0, 1'b0);
    for (int it = 1; it <= 30; it++) begin
      cycle(h, w);
      if (it == 1) req_cmd_valid[0] = 1'b1;
      if (h[1]) begin req_cmd_valid[1] = 1'b0; req_cmd_wr[1] = 1'b0; c1_it = it; end
      if (w[1]) begin
        if (nb < 4) beat_it[nb] = it;
        nb++;
        if (nb == 4) begin req_wvalid[1] = 1'b0; req_weop[1] = 1'b0; end
        else set_beat(1, nb, nb == 3);
      end
      if (h[0]) begin req_cmd_valid[0] = 1'b0; c0_it = it; break; end
    end
    chk("t037_cmd_hs_cycle", c1_it, 2);
    chk("t037_beats", nb, 4);
    chk("t037_beat0_cycle", beat_it[0], 3);
    chk("t037_beat3_cycle", beat_it[3], 6);
    chk("t037_req0_hs_cycle", c0_it, 8);
    cycle(h, w);

    // cmd_ready low for 5 cycles in CMD: command held stable
    set_cmd(1, C4); cmd_ready = 1'b0; req_cmd_valid = 2'b10;
    cycle(h, w);
    hold_ok = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(h, w);
      chk("t038_cv", snap_cv, 1'b1);
      chk("t038_cmd", snap_cmd, C4);
      chk("t038_gnt", snap_gnt, 3'd1);
      if (h == '0 && snap_busy) hold_ok++;
    end
    chk("t038_hold_cycles", hold_ok, 5);
    cmd_ready = 1'b1;
    cycle(h, w);
    chk("t038_release_hs", h, 2'b10);
    req_cmd_valid = '0;
    cycle(h, w);

    // Both continuously valid: grants alternate
    req_cmd_valid = 2'b11; g_n = 0;
    for (int it = 1; it <= 40; it++) begin
      cycle(h, w);
      for (int i = 0; i < NUM_REQ; i++) if (h[i] && g_n < 8) begin g_id[g_n] = i; g_n++; end
      if (g_n >= 6) break;
    end
    req_cmd_valid = '0;
    for (int k = 0; k < 6; k++) chk($sformatf("t039_gnt%0d", k), g_id[k], k % 2);
    cycle(h, w);

    // Reset while beat 2 of a req0 write is presented
    set_cmd(0, C5); req_cmd_wr = 2'b01; req_cmd_valid = 2'b01;
    set_beat(0, 0, 1'b0); nb = 0;
    for (int it = 1; it <= 10; it++) begin
      cycle(h, w);
      if (h[0]) begin req_cmd_valid[0] = 1'b0; req_cmd_wr[0] = 1'b0; end
      if (w[0]) begin nb++; set_beat(0, nb, 1'b0); end
      if (nb == 2) break;
    end
    chk("t040_beats_before_rst", nb, 2);
    rst_n = 1'b0;
    cycle(h, w);
    rst_n = 1'b1;
    cycle(h, w);
    chk("t040_wvalid_after_rst", snap_wv, 1'b0);
    chk("t040_busy_after_rst", snap_busy, 1'b0);
    req_wvalid = '0; req_weop = '0;
    req_cmd_valid = 2'b11; g_id[0] = -1;
    for (int it = 1; it <= 10; it++) begin
      cycle(h, w);
      if (h != '0) begin g_id[0] = h[0] ? 0 : 1; break; end
    end
    chk("t040_gnt_after_rst", g_id[0], 0);
    req_cmd_valid = '0;
    cycle(h, w);
    cycle(h, w);

`ifdef TL_USER_ARB_WDOG_EN
    // Write whose data never arrives: watchdog fires once after WDOG_CYC stalled cycles
    set_cmd(0, C0); req_cmd_wr = 2'b01; req_cmd_valid = 2'b01;
    for (int it = 1; it <= 10; it++) begin
      cycle(h, w);
      if (h[0]) begin req_cmd_valid[0] = 1'b0; req_cmd_wr[0] = 1'b0; break; end
    end
    pulses = 0; pulse_n = -1;
    for (int n = 1; n <= WDOG_CYC + 20; n++) begin
      cycle(h, w);
      if (snap_wdog) begin pulses++; pulse_n = n; break; end
    end
    chk("t041_pulse_cycle", pulse_n, WDOG_CYC);
    cycle(h, w);
    chk("t041_busy_after", snap_busy, 1'b0);
    chk("t041_single_pulse", snap_wdog, 1'b0);
    chk("t041_pulses", pulses, 1);
`else
    pulses = 0; pulse_n = 0;
`endif

    repeat (3) cycle(h, w);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
